// File: rtl/multicycle_ctrl_fsm.sv
// Multicycle CPU control FSM: decodes opcode per state, times out stalled memory handshakes.
// Outputs are combinational from state/inputs; optional retired-instruction counter under PERF_CNT_EN.
module multicycle_ctrl_fsm #(
    parameter int         WAIT_MAX = 15,
    parameter int         CNT_W    = 32,
    parameter logic [5:0] HALT_OP  = 6'b111111
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       opcode,
    input  logic             zero,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             PCWre,
    output logic             IRWre,
    output logic             ALUSrcB,
    output logic             ALUM2Reg,
    output logic             RegWre,
    output logic             WrRegData,
    output logic             DataMemRW,
    output logic [1:0]       ExtSel,
    output logic [1:0]       PCSrc,
    output logic [1:0]       RegOut,
    output logic [2:0]       ALUOp,
    output logic [2:0]       state,
    output logic             halted,
    output logic             bus_err,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        S_IF     = 3'b000,
        S_ID     = 3'b001,
        S_EXE_LS = 3'b010,
        S_MEM    = 3'b011,
        S_WB_LD  = 3'b100,
        S_EXE_BR = 3'b101,
        S_EXE_AL = 3'b110,
        S_WB_AL  = 3'b111
    } state_t;

    localparam logic [5:0] OP_ADD  = 6'b000000;
    localparam logic [5:0] OP_SUB  = 6'b000001;
    localparam logic [5:0] OP_ADDI = 6'b000010;
    localparam logic [5:0] OP_OR   = 6'b010000;
    localparam logic [5:0] OP_AND  = 6'b010001;
    localparam logic [5:0] OP_ORI  = 6'b010010;
    localparam logic [5:0] OP_SLL  = 6'b011000;
    localparam logic [5:0] OP_SLTI = 6'b100111;
    localparam logic [5:0] OP_SW   = 6'b110000;
    localparam logic [5:0] OP_LW   = 6'b110001;
    localparam logic [5:0] OP_BEQ  = 6'b110100;
    localparam logic [5:0] OP_J    = 6'b111000;
    localparam logic [5:0] OP_JR   = 6'b111001;
    localparam logic [5:0] OP_JAL  = 6'b111010;

    localparam int WCW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);

    state_t         state_q, state_d;
    logic [WCW-1:0] wait_q, wait_d;
    logic           halted_q, halted_d;
    logic           bus_err_q, bus_err_d;
    logic           is_rtype, is_itype, timeout;
    logic [2:0]     alu_op;

    always_comb begin
        is_rtype = 1'b0;
        is_itype = 1'b0;
        alu_op   = 3'b000;
        case (opcode)
            OP_ADD:  begin is_rtype = 1'b1; alu_op = 3'b000; end
            OP_SUB:  begin is_rtype = 1'b1; alu_op = 3'b001; end
            OP_OR:   begin is_rtype = 1'b1; alu_op = 3'b011; end
            OP_AND:  begin is_rtype = 1'b1; alu_op = 3'b100; end
            OP_SLL:  begin is_rtype = 1'b1; alu_op = 3'b010; end
            OP_ADDI: begin is_itype = 1'b1; alu_op = 3'b000; end
            OP_ORI:  begin is_itype = 1'b1; alu_op = 3'b011; end
            OP_SLTI: begin is_itype = 1'b1; alu_op = 3'b110; end
            default: ;
        endcase
    end

    // Counter holds the number of stalled cycles already seen; this cycle is the WAIT_MAX-th.
    assign timeout = (wait_q == WCW'(WAIT_MAX - 1));

    always_comb begin
        PCWre     = 1'b0;
        IRWre     = 1'b0;
        ALUSrcB   = 1'b0;
        ALUM2Reg  = 1'b0;
        RegWre    = 1'b0;
        WrRegData = 1'b0;
        DataMemRW = 1'b0;
        ExtSel    = 2'b00;
        PCSrc     = 2'b00;
        RegOut    = 2'b00;
        ALUOp     = 3'b000;
        state_d   = state_q;
        wait_d    = '0;
        halted_d  = halted_q;
        bus_err_d = bus_err_q;
        case (state_q)
            S_IF: begin
                if (halted_q) begin
                    state_d = S_IF;
                end else if (imem_ready) begin
                    IRWre   = 1'b1;
                    state_d = S_ID;
                end else if (timeout) begin
                    halted_d  = 1'b1;
                    bus_err_d = 1'b1;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_ID: begin
                state_d = S_IF;
                if (opcode == HALT_OP) begin
                    halted_d = 1'b1;
                end else if (is_rtype || is_itype) begin
                    state_d = S_EXE_AL;
                end else begin
                    case (opcode)
                        OP_BEQ:       state_d = S_EXE_BR;
                        OP_LW, OP_SW: state_d = S_EXE_LS;
                        OP_J:  begin PCWre = 1'b1; PCSrc = 2'b11; end
                        OP_JR: begin PCWre = 1'b1; PCSrc = 2'b10; end
                        OP_JAL: begin
                            PCWre  = 1'b1;
                            PCSrc  = 2'b11;
                            RegWre = 1'b1;
                        end
                        default: PCWre = 1'b1;
                    endcase
                end
            end
            S_EXE_AL: begin
                ALUOp   = alu_op;
                ALUSrcB = is_itype;
                ExtSel  = (opcode == OP_ORI) ? 2'b00 :
                          (opcode == OP_SLL) ? 2'b10 : 2'b01;
                state_d = S_WB_AL;
            end
            S_WB_AL: begin
                RegWre    = 1'b1;
                WrRegData = 1'b1;
                RegOut    = is_itype ? 2'b01 : 2'b10;
                PCWre     = 1'b1;
                state_d   = S_IF;
            end
            S_EXE_BR: begin
                ALUOp   = 3'b001;
                PCWre   = 1'b1;
                PCSrc   = zero ? 2'b01 : 2'b00;
                state_d = S_IF;
            end
            S_EXE_LS: begin
                ALUSrcB = 1'b1;
                ExtSel  = 2'b01;
                state_d = S_MEM;
            end
            S_MEM: begin
                DataMemRW = (opcode == OP_SW);
                if (dmem_ready) begin
                    PCWre   = (opcode == OP_SW);
                    state_d = (opcode == OP_SW) ? S_IF : S_WB_LD;
                end else if (timeout) begin
                    halted_d  = 1'b1;
                    bus_err_d = 1'b1;
                    state_d   = S_IF;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_WB_LD: begin
                RegWre    = 1'b1;
                ALUM2Reg  = 1'b1;
                WrRegData = 1'b1;
                RegOut    = 2'b01;
                PCWre     = 1'b1;
                state_d   = S_IF;
            end
            default: state_d = S_IF;
        endcase
        // Reset must silence the strobes at once, not on the next edge.
        if (!reset) begin
            PCWre     = 1'b0;
            IRWre     = 1'b0;
            ALUSrcB   = 1'b0;
            ALUM2Reg  = 1'b0;
            RegWre    = 1'b0;
            WrRegData = 1'b0;
            DataMemRW = 1'b0;
            ExtSel    = 2'b00;
            PCSrc     = 2'b00;
            RegOut    = 2'b00;
            ALUOp     = 3'b000;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IF;
            wait_q    <= '0;
            halted_q  <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            halted_q  <= halted_d;
            bus_err_q <= bus_err_d;
        end
    end

`ifdef PERF_CNT_EN
    logic [CNT_W-1:0] instret_q, instret_d;

    assign instret_d = instret_q + CNT_W'(PCWre);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instret_q <= '0;
        end else begin
            instret_q <= instret_d;
        end
    end

    assign instret = instret_q;
`else
    assign instret = '0;
`endif

    assign state   = state_q;
    assign halted  = halted_q;
    assign bus_err = bus_err_q;

endmodule

// File: doc/multicycle_ctrl_fsm.md
MULTICYCLE_CTRL_FSM -- requirements
Module: multicycle_ctrl_fsm

Interface
REQ-001 SHALL have parameter WAIT_MAX, default 15, the number of wait cycles tolerated on a memory ready handshake before a bus error is declared.
REQ-002 SHALL have parameter CNT_W, default 32, the width of the retired-instruction counter.
REQ-003 SHALL have parameter HALT_OP, default 6'b111111, the halt opcode.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 opcode  in  6  instruction opcode field from IR.
REQ-007 zero  in  1  ALU zero flag.
REQ-008 imem_ready  in  1  instruction memory data valid.
REQ-009 dmem_ready  in  1  data memory access complete.
REQ-010 PCWre  out  1  PC write enable.
REQ-011 IRWre  out  1  IR write enable.
REQ-012 ALUSrcB  out  1  ALU B operand select: 0 = register, 1 = extended immediate.
REQ-013 ALUM2Reg  out  1  writeback source select: 0 = ALU, 1 = data memory.
REQ-014 RegWre  out  1  register file write enable.
REQ-015 WrRegData  out  1  writeback data select: 0 = PC+4, 1 = ALU/memory.
REQ-016 DataMemRW  out  1  data memory direction: 0 = read, 1 = write.
REQ-017 ExtSel  out  2  extender mode: 00 = zero, 01 = sign, 10 = shamt.
REQ-018 PCSrc  out  2  next-PC select: 00 = PC+4, 01 = branch, 10 = JR, 11 = J.
REQ-019 RegOut  out  2  destination register select: 00 = $31, 01 = rt, 10 = rd.
REQ-020 ALUOp  out  3  ALU operation code.
REQ-021 state  out  3  current FSM state.
REQ-022 halted  out  1  sticky halt flag.
REQ-023 bus_err  out  1  sticky handshake-timeout flag.
REQ-024 instret  out  CNT_W  retired-instruction count.

Function
REQ-025 State encodings SHALL be IF=000, ID=001, EXE_LS=010, MEM=011, WB_LD=100, EXE_BR=101, EXE_AL=110, WB_AL=111.
REQ-026 Opcodes SHALL decode as follows (opcode -> instruction, ALUOp):
- 000000 ADD, 000
- 000001 SUB, 001
- 000010 ADDI, 000
- 010000 OR, 011
- 010001 AND, 100
- 010010 ORI, 011
- 011000 SLL, 010
- 100111 SLTI, 110
- 110000 SW
- 110001 LW
- 110100 BEQ
- 111000 J
- 111001 JR
- 111010 JAL
REQ-027 Outputs SHALL be combinational functions of state, opcode, zero and the ready inputs; every output not named for a state SHALL be 0 in that state.
REQ-028 IF: IRWre=imem_ready; the FSM SHALL go to ID on imem_ready and hold IF otherwise; it SHALL hold IF with IRWre=0 while halted=1.
REQ-029 ID branches by opcode:
- ALU ops -> EXE_AL.
- BEQ -> EXE_BR.
- LW/SW -> EXE_LS.
- J: PCWre=1, PCSrc=11 -> IF.
- JR: PCWre=1, PCSrc=10 -> IF.
- JAL: PCWre=1, PCSrc=11, RegWre=1, WrRegData=0, RegOut=00 -> IF.
- HALT_OP: set halted -> IF.
- Undefined opcode: PCWre=1 (NOP) -> IF.
REQ-030 EXE_AL: ALUSrcB=1 for ADDI/ORI/SLTI; ExtSel=00 for ORI, 10 for SLL, 01 otherwise; -> WB_AL.
REQ-031 WB_AL: RegWre=1, WrRegData=1, RegOut=10 for R-type and 01 for I-type, PCWre=1; -> IF.
REQ-032 EXE_BR: ALUOp=001, PCWre=1, PCSrc=01 if zero else 00; -> IF (one cycle, no wait).
REQ-033 EXE_LS: ALUSrcB=1, ExtSel=01, ALUOp=000; -> MEM.
REQ-034 MEM, SW: DataMemRW=1; on dmem_ready assert PCWre=1 and go to IF.
REQ-035 MEM, LW: on dmem_ready go to WB_LD.
REQ-036 MEM: hold MEM while dmem_ready=0.
REQ-037 WB_LD: RegWre=1, ALUM2Reg=1, WrRegData=1, RegOut=01, PCWre=1; -> IF.
REQ-038 A wait counter SHALL increment each cycle spent in IF or MEM without ready and SHALL clear on any state change.
REQ-039 When the wait counter equals WAIT_MAX without ready, the FSM SHALL set bus_err and halted and go to IF.
REQ-040 If ready coincides with the wait counter reaching WAIT_MAX, ready SHALL win and no error is flagged.
REQ-041 halted and bus_err SHALL clear only on reset.

Reset
REQ-042 On reset low, state SHALL go to IF, the wait counter, halted, bus_err and instret SHALL clear, and all control outputs SHALL be 0, immediately and irrespective of clk, including mid-MEM.
REQ-043 On release of reset, the first IF SHALL begin on the next rising edge.

Configuration
REQ-044 With PERF_CNT_EN defined, instret SHALL increment by one on every cycle with PCWre=1 and wrap from all-ones to 0; without the macro, instret SHALL be constant 0 and the port SHALL remain present.

Verification
REQ-045 ADD with imem_ready=1 -> states IF, ID, EXE_AL, WB_AL, IF; WB_AL has RegWre=1, RegOut=10, PCWre=1.
REQ-046 LW with dmem_ready delayed 3 cycles -> MEM held 4 cycles, then WB_LD with ALUM2Reg=1; instret +1 (PERF_CNT_EN).
REQ-047 BEQ with zero=1 -> EXE_BR has PCSrc=01, PCWre=1; with zero=0 -> PCSrc=00.
REQ-048 imem_ready held 0 for 15 cycles (WAIT_MAX=15) -> bus_err=1, halted=1, IRWre stays 0; ready on the 15th cycle instead -> no error.
REQ-049 Reset asserted in MEM during SW -> state=000 and DataMemRW=0 asynchronously, flags and instret 0.
